// File: rtl/sobol_sng_pkg.sv
// sobol_pkg: shared definitions for the Sobol stochastic number generator.
//   SOBOL_W     : width of one serial Sobol sample
//   SOBOL_FRAME : samples per frame (matches the generator's sample counter)
//   ONES_W      : width needed to hold 0..SOBOL_FRAME ones
//   sng_state_t : controller state encoding
package sobol_pkg;

  localparam int SOBOL_W     = 6;
  localparam int SOBOL_FRAME = 32;
  localparam int ONES_W      = $clog2(SOBOL_FRAME + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } sng_state_t;

endpackage

// File: rtl/sobol_sng_deser.sv
// sobol_deser: serial-to-parallel converter for LSB-first Sobol samples.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   clr        : synchronous clear (drops any partial word, no truncation flag)
//   act        : controller is collecting; bits are ignored when low
//   in_valid   : serial strobe
//   in_bit     : serial data, LSB first
//   word       : assembled sample, valid with word_valid
//   word_valid : combinational, high on the cycle the W-th bit arrives
//   word_first : combinational, high on the cycle the first bit of a word arrives
//   trunc      : combinational, high when in_valid drops with a partial word held
module sobol_deser
  import sobol_pkg::*;
#(
  parameter int W = SOBOL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         act,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic [W-1:0] word,
  output logic         word_valid,
  output logic         word_first,
  output logic         trunc
);

  localparam int IDX_W = $clog2(W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Only the first W-1 bits need storing; the final bit is used straight
  // from in_bit on the cycle it arrives.
  logic [W-2:0]     shreg;
  logic [IDX_W-1:0] bit_idx;
  logic             capture;

  assign capture    = act && in_valid;
  assign word_valid = capture && (bit_idx == IDX_LAST);
  assign word_first = capture && (bit_idx == '0);
  assign trunc      = act && !in_valid && (bit_idx != '0);
  assign word       = {in_bit, shreg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (word_valid) begin
      // Overrun: a still-high in_valid simply starts the next word at bit 0.
      bit_idx <= '0;
    end else if (capture) begin
      for (int i = 0; i < W - 1; i++) begin
        if (bit_idx == IDX_W'(i)) begin
          shreg[i] <= in_bit;
        end
      end
      bit_idx <= bit_idx + IDX_ONE;
    end else if (trunc) begin
      shreg   <= '0;
      bit_idx <= '0;
    end
  end

endmodule

// File: rtl/sobol_sng.sv
// sobol_sng: stochastic number generator fed by a serial Sobol generator.
// Each deserialised sample is compared against the latched operand x to form
// one stochastic bit; ones are totalled per FRAME samples for readback.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   en_in      : block enable; low synchronously clears all state
//   in_valid   : serial sample strobe from the Sobol generator
//   in_bit     : serial sample data, LSB first
//   x          : operand, latched at the first bit of each frame
//   sc_bit     : stochastic bit (sample < x), held between sc_valid pulses
//   sc_valid   : one-cycle strobe qualifying sc_bit
//   frame_done : one-cycle strobe with the sc_valid of the last frame sample
//   ones_count : ones in the last completed frame, held between frames
//   err        : sticky truncated-sample flag
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | disabled or just reset; everything cleared
// COLLECT | waiting for or shifting in a sample
module sobol_sng
  import sobol_pkg::*;
#(
  parameter int W     = SOBOL_W,
  parameter int FRAME = SOBOL_FRAME
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_in,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic [W-1:0]                 x,
  output logic                         sc_bit,
  output logic                         sc_valid,
  output logic                         frame_done,
  output logic [$clog2(FRAME+1)-1:0]   ones_count,
  output logic                         err
);

  localparam int OW    = $clog2(FRAME + 1);
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sng_state_t       state;
  logic [W-1:0]     x_lat;
  logic [W-1:0]     x_eff;
  logic [CNT_W-1:0] samp_cnt;
  logic [OW-1:0]    acc;
  logic             active;
  logic             x_load;
  logic             cmp;

  logic [W-1:0]     word;
  logic             word_valid;
  logic             word_first;
  logic             trunc;

  assign active = (state == COLLECT) && en_in;

  sobol_deser #(
    .W (W)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .clr        (!en_in),
    .act        (active),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .word       (word),
    .word_valid (word_valid),
    .word_first (word_first),
    .trunc      (trunc)
  );

  // The operand is captured on the first bit of sample 0. Bypassing the
  // register on that cycle keeps the compare correct even for tiny W.
  assign x_load = word_first && (samp_cnt == '0);
  assign x_eff  = x_load ? x : x_lat;
  assign cmp    = word < x_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x_lat      <= '0;
      samp_cnt   <= '0;
      acc        <= '0;
      sc_bit     <= 1'b0;
      sc_valid   <= 1'b0;
      frame_done <= 1'b0;
      ones_count <= '0;
      err        <= 1'b0;
    end else if (!en_in) begin
      state      <= IDLE;
      x_lat      <= '0;
      samp_cnt   <= '0;
      acc        <= '0;
      sc_bit     <= 1'b0;
      sc_valid   <= 1'b0;
      frame_done <= 1'b0;
      ones_count <= '0;
      err        <= 1'b0;
    end else begin
      sc_valid   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          state <= COLLECT;
        end
        COLLECT: begin
          if (x_load) begin
            x_lat <= x;
          end
          if (word_valid) begin
            sc_bit   <= cmp;
            sc_valid <= 1'b1;
            if (samp_cnt == CNT_LAST) begin
              ones_count <= acc + OW'(cmp);
              frame_done <= 1'b1;
              acc        <= '0;
              samp_cnt   <= '0;
            end else begin
              acc      <= acc + OW'(cmp);
              samp_cnt <= samp_cnt + CNT_ONE;
            end
          end
          // A dropped partial word leaves samp_cnt and acc untouched.
          if (trunc) begin
            err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobol_sng.sv
module tb_sobol_sng;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic [5:0] x = 6'd0;
  logic       sc_bit;
  logic       sc_valid;
  logic       frame_done;
  logic [5:0] ones_count;
  logic       err;

  sobol_sng dut (
    .clk        (clk),
    .rst        (rst),
    .en_in      (en_in),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .x          (x),
    .sc_bit     (sc_bit),
    .sc_valid   (sc_valid),
    .frame_done (frame_done),
    .ones_count (ones_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int due;
    bit sc;
    bit fd;
    int ones;
  } exp_t;

  exp_t q[$];

  // Reference model state: position in frame, running ones, last frame total.
  int         frame_pos = 0;
  int         acc_m = 0;
  int         last_ones = 0;
  logic [5:0] x_frame = 6'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] vdc(input int i);
    logic [5:0] v;
    logic [5:0] r;
    v = 6'(i);
    for (int b = 0; b < 6; b++) r[b] = v[5 - b];
    return r;
  endfunction

  task automatic drive_bit(input logic v, input logic b);
    @(posedge clk);
    #1;
    in_valid = v;
    in_bit   = b;
  endtask

  task automatic model_clear();
    frame_pos = 0;
    acc_m     = 0;
    last_ones = 0;
  endtask

  task automatic send_sample(input logic [5:0] val, input int gap);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 && frame_pos == 0) x_frame = x;
      drive_bit(1'b1, val[i]);
    end
    e.due = cyc + 1;
    e.sc  = (val < x_frame);
    e.fd  = 1'b0;
    if (frame_pos == 31) begin
      last_ones = acc_m + int'(e.sc);
      acc_m     = 0;
      frame_pos = 0;
      e.fd      = 1'b1;
    end else begin
      acc_m     = acc_m + int'(e.sc);
      frame_pos = frame_pos + 1;
    end
    e.ones = last_ones;
    q.push_back(e);
    repeat (gap) drive_bit(1'b0, 1'b0);
  endtask

  task automatic send_vdc_frame();
    for (int i = 0; i < 32; i++) send_sample(vdc(i), 1);
  endtask

  task automatic wait_drain();
    int n;
    drive_bit(1'b0, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic clear_en();
    wait_drain();
    @(posedge clk);
    #1;
    en_in    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    en_in = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  // Monitor: every sc_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (sc_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sc_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("sc_valid_cycle", cyc, e.due);
          chk("sc_bit", int'(sc_bit), int'(e.sc));
          chk("frame_done", int'(frame_done), int'(e.fd));
          chk("ones_count", int'(ones_count), e.ones);
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_without_sc_valid: got 1 expected 0 (t=%0t)", $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #23;
    chk("rst_sc_bit", int'(sc_bit), 0);
    chk("rst_sc_valid", int'(sc_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_ones_count", int'(ones_count), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    en_in = 1'b1;
    repeat (2) @(posedge clk);

    // Van der Corput frames with x = 32, 0, 63
    x = 6'd32;
    send_vdc_frame();
    wait_drain();
    chk("vdc_x32_ones", int'(ones_count), 16);
    x = 6'd0;
    send_vdc_frame();
    wait_drain();
    chk("vdc_x0_ones", int'(ones_count), 0);
    x = 6'd63;
    send_vdc_frame();
    wait_drain();
    chk("vdc_x63_ones", int'(ones_count), 32);

    // Compare boundary: sample 0x2A against 0x2B and 0x2A
    clear_en();
    x = 6'h2B;
    send_sample(6'h2A, 1);
    wait_drain();
    chk("cmp_2a_lt_2b", int'(sc_bit), 1);
    clear_en();
    x = 6'h2A;
    send_sample(6'h2A, 1);
    wait_drain();
    chk("cmp_2a_eq_2a", int'(sc_bit), 0);

    // Truncation: 3 bits then drop; frame still counts 32 full words
    clear_en();
    chk("err_after_clear", int'(err), 0);
    x = 6'h20;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)));
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    @(negedge clk);
    chk("err_after_trunc", int'(err), 1);
    for (int i = 0; i < 32; i++) send_sample(6'($urandom_range(0, 63)), 1);
    wait_drain();
    chk("err_sticky", int'(err), 1);

    // Back-to-back overrun: 0x05 then 0x3C with x = 0x10
    clear_en();
    x = 6'h10;
    send_sample(6'h05, 0);
    send_sample(6'h3C, 0);
    wait_drain();

    // Randomized frames, x changes mid-frame are ignored
    clear_en();
    x = 6'($urandom_range(0, 63));
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 32; s++) begin
        if ($urandom_range(0, 3) == 0) x = 6'($urandom_range(0, 63));
        send_sample(6'($urandom_range(0, 63)), $urandom_range(0, 2));
      end
    end
    wait_drain();

    // Asynchronous reset in the middle of sample 17
    x = 6'd40;
    for (int i = 0; i < 17; i++) send_sample(6'($urandom_range(0, 63)), 1);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_sc_bit", int'(sc_bit), 0);
    chk("arst_sc_valid", int'(sc_valid), 0);
    chk("arst_frame_done", int'(frame_done), 0);
    chk("arst_ones_count", int'(ones_count), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_queue_empty", q.size(), 0);
    q.delete();
    model_clear();
    in_valid = 1'b0;
    #10;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    x = 6'($urandom_range(1, 62));
    send_vdc_frame();
    wait_drain();

    // en_in low for one cycle mid-sample: partial word dropped, no err
    x = 6'd24;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    @(posedge clk);
    #1;
    en_in = 1'b0;
    @(posedge clk);
    #1;
    en_in    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    x = 6'd24;
    send_vdc_frame();
    wait_drain();
    chk("en_drop_ones", int'(ones_count), 12);
    chk("en_drop_err", int'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobol_sng.md
# sobol_sng

Stochastic number generator stage directly downstream of the serial Sobol generator. It deserialises each 6-bit Sobol sample (LSB first) and compares it against a binary operand `x` to emit one stochastic bit per sample. It also accumulates the number of ones over a 32-sample frame, which aligns with the generator's 0..31 sample counter. Its output bitstream feeds the stochastic arithmetic datapath; `ones_count` gives a binary readback for checking.

## Interface
- `W`, 6, Sobol sample width in bits
- `FRAME`, 32, samples per frame; `ones_count` width is `$clog2(FRAME+1)`
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en_in`  in  1  block enable; low acts as a synchronous clear of all state
- `in_valid`  in  1  serial sample strobe from the Sobol generator (`en_out`)
- `in_bit`  in  1  serial sample data (`out_bit`), LSB first
- `x`  in  W  binary operand to encode; sampled at frame start
- `sc_bit`  out  1  stochastic bit, `1` when sample < latched `x`
- `sc_valid`  out  1  one-cycle strobe qualifying `sc_bit`
- `frame_done`  out  1  one-cycle strobe on the last sample of a frame
- `ones_count`  out  $clog2(FRAME+1)  ones in the last completed frame; held between frames
- `err`  out  1  sticky truncated-sample flag

## Operation
- States:
  - IDLE: `en_in` low or just reset.
  - COLLECT: waiting for or shifting a sample.
- IDLE -> COLLECT when `en_in` = 1. Any state -> IDLE when `en_in` = 0. On entering IDLE, all counters, the shift register, `err`, and all outputs clear to 0.
- In COLLECT, each cycle with `in_valid` = 1 captures `in_bit` into bit position `bit_idx` of `shreg`, then increments `bit_idx`.
- On the cycle the W-th bit is captured:
  - Form `sample` = `{in_bit, shreg[W-2:0]}`.
  - Compute `sc_bit <= (sample < x_lat)`. The comparison is unsigned, W bits wide.
  - Assert `sc_valid <= 1`.
  - Reset `bit_idx` to 0.
- `x_lat` loads `x` on the first `in_valid` cycle of sample 0 of each frame. `x` changes mid-frame are ignored.
- Frame counting:
  - `samp_cnt` counts completed samples 0..FRAME-1 and wraps to 0.
  - `acc` adds `sc_bit` per completed sample.
  - On sample FRAME-1: `ones_count <= acc + cmp`, `frame_done <= 1`, `acc <= 0`.
- Truncation: if `in_valid` falls with 0 < `bit_idx` < W, discard the partial word. Reset `bit_idx` to 0, set `err` (sticky until `en_in` low or `rst`). `samp_cnt` and `acc` are unchanged.
- Overrun: if `in_valid` stays high past W bits, the next bit starts a new sample. No gap is required.

## Timing
- Reset values: `sc_bit`, `sc_valid`, `frame_done`, `ones_count`, and `err` are all 0. Internal counters and `x_lat` are also 0.
- Latency: `sc_valid` is high the cycle after the W-th `in_valid` cycle. It lasts exactly 1 cycle.
- `frame_done` is coincident with the `sc_valid` of sample FRAME-1. `ones_count` is valid from that cycle and holds until the next `frame_done`.
- `sc_bit` holds its value until the next `sc_valid`.
- Asynchronous `rst` low at any point clears everything immediately. After release, the block starts at sample 0 with `bit_idx` 0.
- `en_in` falling mid-sample discards the partial word and does not set `err`. Clear has priority over the truncation rule.
- Throughput: one sample per W cycles minimum.
- `ones_count` range is 0..FRAME, so 32 must be representable.

## Structure
- Shared package `sobol_pkg` holds:
  - `SOBOL_W` = 6
  - `SOBOL_FRAME` = 32
  - the `sng_state_t` enum {IDLE, COLLECT}
  - the `ONES_W` localparam
- Sub-module `sobol_deser`:
  - Contains the shift register, `bit_idx`, and truncation detection.
  - Outputs `word[W-1:0]`, `word_valid` (combinational on the W-th bit), and `trunc`.
- Top-level `sobol_sng` contains the comparator, `x_lat`, frame counter, accumulator, and output registers.

## Test plan
- Frame of 32 dim-1 van der Corput samples (even values 0..62 in bit-reversed order, each sent serially LSB first, 6-cycle bursts separated by 1 idle cycle), `x` = 32 -> 32 `sc_valid` pulses, `frame_done` on the 32nd, `ones_count` = 16.
- Same stream, `x` = 0 -> all `sc_bit` = 0, `ones_count` = 0; `x` = 63 -> all `sc_bit` = 1, `ones_count` = 32.
- Sample 0x2A with `x` = 0x2B -> `sc_bit` = 1; with `x` = 0x2A -> `sc_bit` = 0. `sc_valid` occurs exactly 1 cycle after the 6th bit.
- `in_valid` high for 3 cycles then low -> no `sc_valid`, `err` = 1 and stays set. A following full sample produces a normal `sc_valid`, and `samp_cnt` is unchanged by the truncated word.
- Back-to-back 12-cycle `in_valid` carrying 0x05 then 0x3C, `x` = 0x10 -> two `sc_valid` pulses 6 cycles apart with `sc_bit` 1 then 0.
- `rst` low at sample 17 -> all outputs 0 immediately. After release, a full 32-sample frame yields a correct `ones_count`. Repeat with `en_in` low for 1 cycle mid-sample -> partial word dropped, `err` stays 0.
